// File: rtl/pc_gen_multi.sv
// N-wide fetch PC generator: one fetch group per cycle, never crossing an I-cache line.
// Ports: clk, rst (async active-low), stall, flush/flush_pc, branch_valid/branch_target,
//        fetch_ready in; fetch_valid, fetch_pc, fetch_lane_valid, fetch_lane_pc, fetch_adef out.
module pc_gen_multi #(
    parameter int ADDR_WIDTH = 32,
    parameter int FETCH_WIDTH = 2,
    parameter int LINE_BYTES = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 'h1c000000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              stall,
    input  logic                              flush,
    input  logic [ADDR_WIDTH-1:0]             flush_pc,
    input  logic [FETCH_WIDTH-1:0]            branch_valid,
    input  logic [FETCH_WIDTH*ADDR_WIDTH-1:0] branch_target,
    input  logic                              fetch_ready,
    output logic                              fetch_valid,
    output logic [ADDR_WIDTH-1:0]             fetch_pc,
    output logic [FETCH_WIDTH-1:0]            fetch_lane_valid,
    output logic [FETCH_WIDTH*ADDR_WIDTH-1:0] fetch_lane_pc,
    output logic                              fetch_adef
);

    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int CNT_W = $clog2(FETCH_WIDTH) + 1;

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pend_target;
    logic                  pend_valid;
    logic                  started;

    logic                  misalign;
    logic                  acc;
    logic [OFF_W:0]        room;
    logic [OFF_W-2:0]      slots;
    logic [CNT_W-1:0]      cnt;
    logic                  br_any;
    logic [ADDR_WIDTH-1:0] br_target;
    logic [ADDR_WIDTH-1:0] seq_pc;

    assign fetch_valid = started;
    assign fetch_pc    = pc;
    assign misalign    = (pc[1:0] != 2'b00);
    assign fetch_adef  = fetch_valid & misalign;
    assign acc         = fetch_valid & fetch_ready & ~stall;

    // Bytes left in the current line, then whole instruction slots left.
    assign room  = (OFF_W+1)'(LINE_BYTES) - {1'b0, pc[OFF_W-1:0]};
    assign slots = room[OFF_W:2];

    always_comb begin
        fetch_lane_valid = '0;
        cnt = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            // A misaligned base only ever presents lane 0 so the fault is reported once.
            fetch_lane_valid[i] = fetch_valid &
                ((i == 0) | (~misalign & (i < int'(slots))));
            cnt = cnt + CNT_W'(fetch_lane_valid[i]);
        end
    end

    always_comb begin
        fetch_lane_pc = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            fetch_lane_pc[i*ADDR_WIDTH +: ADDR_WIDTH] = pc + ADDR_WIDTH'(4 * i);
        end
    end

    // Oldest (lowest-index) resolved branch wins.
    always_comb begin
        br_target = '0;
        for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
            if (branch_valid[i]) begin
                br_target = branch_target[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign br_any = |branch_valid;
    assign seq_pc = pc + (ADDR_WIDTH'(cnt) << 2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            pend_valid  <= 1'b0;
            pend_target <= '0;
            started     <= 1'b0;
        end else begin
            started <= 1'b1;
            if (started) begin
                if (flush) begin
                    pc         <= flush_pc;
                    pend_valid <= 1'b0;
                end else if (stall && br_any) begin
                    pend_valid  <= 1'b1;
                    pend_target <= br_target;
                end else if (stall) begin
                    pc <= pc;
                end else if (br_any) begin
                    pc         <= br_target;
                    pend_valid <= 1'b0;
                end else if (pend_valid) begin
                    pc         <= pend_target;
                    pend_valid <= 1'b0;
                end else if (acc && !misalign) begin
                    pc <= seq_pc;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_gen_multi.sv
// Directed bench for pc_gen_multi: a 2-wide instance (main) and a 4-wide one (line split).
// Expected groups are queued when stimulus is driven and checked after the next edge.
module tb_pc_gen_multi;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        a_stall = 1'b0;
    logic        a_flush = 1'b0;
    logic [31:0] a_flush_pc = '0;
    logic [1:0]  a_bv = '0;
    logic [63:0] a_bt = '0;
    logic        a_ready = 1'b1;
    logic        a_valid;
    logic [31:0] a_pc;
    logic [1:0]  a_lanes;
    logic [63:0] a_lane_pc;
    logic        a_adef;

    logic         b_flush = 1'b0;
    logic [31:0]  b_flush_pc = '0;
    logic         b_valid;
    logic [31:0]  b_pc;
    logic [3:0]   b_lanes;
    logic [127:0] b_lane_pc;
    logic         b_adef;

    int total = 0;
    int passed = 0;

    typedef struct {
        bit          sel;
        logic [31:0] pc;
        logic [7:0]  lanes;
        logic        adef;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    pc_gen_multi #(.ADDR_WIDTH(32), .FETCH_WIDTH(2), .LINE_BYTES(16),
                   .RESET_PC(32'h1c000000)) dut (
        .clk(clk), .rst(rst), .stall(a_stall), .flush(a_flush),
        .flush_pc(a_flush_pc), .branch_valid(a_bv), .branch_target(a_bt),
        .fetch_ready(a_ready), .fetch_valid(a_valid), .fetch_pc(a_pc),
        .fetch_lane_valid(a_lanes), .fetch_lane_pc(a_lane_pc),
        .fetch_adef(a_adef)
    );

    pc_gen_multi #(.ADDR_WIDTH(32), .FETCH_WIDTH(4), .LINE_BYTES(16),
                   .RESET_PC(32'h1c000000)) dut4 (
        .clk(clk), .rst(rst), .stall(1'b0), .flush(b_flush),
        .flush_pc(b_flush_pc), .branch_valid(4'b0000), .branch_target(128'd0),
        .fetch_ready(1'b1), .fetch_valid(b_valid), .fetch_pc(b_pc),
        .fetch_lane_valid(b_lanes), .fetch_lane_pc(b_lane_pc),
        .fetch_adef(b_adef)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic push(input bit sel, input logic [31:0] pc,
                        input logic [7:0] lanes, input logic adef);
        exp_t e;
        e.sel = sel;
        e.pc = pc;
        e.lanes = lanes;
        e.adef = adef;
        q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (q.size() > 0) begin
            e = q.pop_front();
            if (!e.sel) begin
                chk("a_valid", 64'(a_valid), 64'(1'b1));
                chk("a_pc", 64'(a_pc), 64'(e.pc));
                chk("a_lanes", 64'(a_lanes), 64'(e.lanes));
                chk("a_adef", 64'(a_adef), 64'(e.adef));
                chk("a_lane_pc1", 64'(a_lane_pc[63:32]), 64'(e.pc + 32'd4));
            end else begin
                chk("b_valid", 64'(b_valid), 64'(1'b1));
                chk("b_pc", 64'(b_pc), 64'(e.pc));
                chk("b_lanes", 64'(b_lanes), 64'(e.lanes));
                chk("b_adef", 64'(b_adef), 64'(e.adef));
                chk("b_lane_pc3", 64'(b_lane_pc[127:96]), 64'(e.pc + 32'd12));
            end
        end
    endtask

    initial begin
        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_valid", 64'(a_valid), 64'd0);
        chk("rst_lanes", 64'(a_lanes), 64'd0);
        chk("rst_adef", 64'(a_adef), 64'd0);
        chk("rst_pc", 64'(a_pc), 64'h1c000000);
        rst = 1'b1;
        chk("start_valid", 64'(a_valid), 64'd0);

        // Start-up and sequential advance
        push(0, 32'h1c000000, 8'b11, 1'b0); tick();
        push(0, 32'h1c000008, 8'b11, 1'b0); tick();

        // Backpressure at 0x20
        a_flush = 1'b1; a_flush_pc = 32'h1c000020;
        push(0, 32'h1c000020, 8'b11, 1'b0); tick();
        a_flush = 1'b0; a_ready = 1'b0;
        push(0, 32'h1c000020, 8'b11, 1'b0); tick();
        push(0, 32'h1c000020, 8'b11, 1'b0); tick();
        push(0, 32'h1c000020, 8'b11, 1'b0); tick();
        a_ready = 1'b1;
        push(0, 32'h1c000028, 8'b11, 1'b0); tick();

        // Branch during stall is held, applied on release
        a_stall = 1'b1; a_bv = 2'b10; a_bt = {32'h1c000100, 32'h1c0000f0};
        push(0, 32'h1c000028, 8'b11, 1'b0); tick();
        chk("pend_set", 64'(dut.pend_valid), 64'd1);
        a_bv = 2'b00;
        push(0, 32'h1c000028, 8'b11, 1'b0); tick();
        a_stall = 1'b0;
        push(0, 32'h1c000100, 8'b11, 1'b0); tick();
        chk("pend_clr", 64'(dut.pend_valid), 64'd0);

        // Flush in the release cycle drops the pending branch
        a_stall = 1'b1; a_bv = 2'b10; a_bt = {32'h1c000180, 32'h1c0000f0};
        push(0, 32'h1c000100, 8'b11, 1'b0); tick();
        chk("pend_set2", 64'(dut.pend_valid), 64'd1);
        a_stall = 1'b0; a_bv = 2'b00;
        a_flush = 1'b1; a_flush_pc = 32'h1c000800;
        push(0, 32'h1c000800, 8'b11, 1'b0); tick();
        chk("pend_drop", 64'(dut.pend_valid), 64'd0);
        a_flush = 1'b0;
        push(0, 32'h1c000808, 8'b11, 1'b0); tick();

        // Simultaneous redirects
        a_bv = 2'b11; a_bt = {32'h1c000300, 32'h1c000200};
        push(0, 32'h1c000200, 8'b11, 1'b0); tick();
        a_flush = 1'b1; a_flush_pc = 32'h1c000400;
        push(0, 32'h1c000400, 8'b11, 1'b0); tick();
        a_flush = 1'b0; a_bv = 2'b00;
        push(0, 32'h1c000408, 8'b11, 1'b0); tick();

        // Misaligned target holds with only lane 0
        a_bv = 2'b01; a_bt = {32'h1c000300, 32'h1c000102};
        push(0, 32'h1c000102, 8'b01, 1'b1); tick();
        a_bv = 2'b00;
        push(0, 32'h1c000102, 8'b01, 1'b1); tick();
        push(0, 32'h1c000102, 8'b01, 1'b1); tick();
        a_flush = 1'b1; a_flush_pc = 32'h1c000000;
        push(0, 32'h1c000000, 8'b11, 1'b0); tick();
        a_flush = 1'b0;
        push(0, 32'h1c000008, 8'b11, 1'b0); tick();

        // Line boundary on the 2-wide unit
        a_flush = 1'b1; a_flush_pc = 32'h1c00000c;
        push(0, 32'h1c00000c, 8'b01, 1'b0); tick();
        a_flush = 1'b0;
        push(0, 32'h1c000010, 8'b11, 1'b0); tick();

        // Reset mid-operation with a branch pending
        a_stall = 1'b1; a_bv = 2'b10; a_bt = {32'h1c000500, 32'h1c0000f0};
        push(0, 32'h1c000010, 8'b11, 1'b0); tick();
        chk("pend_pre_rst", 64'(dut.pend_valid), 64'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(a_valid), 64'd0);
        chk("mid_rst_lanes", 64'(a_lanes), 64'd0);
        chk("mid_rst_pc", 64'(a_pc), 64'h1c000000);
        chk("mid_rst_pend", 64'(dut.pend_valid), 64'd0);
        rst = 1'b1; a_stall = 1'b0; a_bv = 2'b00;
        push(0, 32'h1c000000, 8'b11, 1'b0); tick();
        push(0, 32'h1c000008, 8'b11, 1'b0); tick();

        // Line split on the 4-wide unit
        b_flush = 1'b1; b_flush_pc = 32'h1c000008;
        push(1, 32'h1c000008, 8'b0011, 1'b0); tick();
        b_flush = 1'b0;
        push(1, 32'h1c000010, 8'b1111, 1'b0); tick();
        push(1, 32'h1c000020, 8'b1111, 1'b0); tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pc_gen_multi.md
Name: pc_gen_multi

Overview:
- N-wide successor to the dual-issue PC register. Produces one fetch group per cycle: a base PC plus FETCH_WIDTH lane PCs with per-lane valid bits.
- Fetch groups never cross an I-cache line boundary.
- Redirect priority: flush, then branch, then sequential.
- Uses a valid/ready handshake to the I-cache.
- Holds branch redirects that arrive during a stall and applies them when the stall releases.
- Sits between the backend redirect sources and the instruction fetch stage.

Parameters:
- ADDR_WIDTH, 32: PC width.
- FETCH_WIDTH, 2: lanes per group. Power of two, 1 to 8.
- LINE_BYTES, 16: I-cache line size in bytes. Power of two, at least 4*FETCH_WIDTH.
- RESET_PC, 32'h1c000000: first fetch address.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  freeze PC and hold outputs.
- flush  in  1  exception/ertn redirect; highest priority.
- flush_pc  in  ADDR_WIDTH  flush target.
- branch_valid  in  FETCH_WIDTH  per-lane branch resolution.
- branch_target  in  FETCH_WIDTH*ADDR_WIDTH  lane i target in bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- fetch_ready  in  1  I-cache accepts the group.
- fetch_valid  out  1  group valid.
- fetch_pc  out  ADDR_WIDTH  group base PC.
- fetch_lane_valid  out  FETCH_WIDTH  lane i valid.
- fetch_lane_pc  out  FETCH_WIDTH*ADDR_WIDTH  lane i PC = fetch_pc + 4*i.
- fetch_adef  out  1  base PC misaligned (fetch_pc[1:0] != 0).

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, fetch_valid=0, fetch_adef=0, fetch_lane_valid=0.
  - pend_valid=0, pend_target=0, started=0.
- Start-up:
  - First edge with rst=1 sets started=1.
  - fetch_valid=started. The first group is presented one cycle after reset release.
- Lane validity, combinational from pc:
  - Lane i is valid iff i < (LINE_BYTES - pc mod LINE_BYTES)/4 and fetch_valid=1.
  - Lane 0 is always valid when fetch_valid=1.
  - cnt = number of valid lanes.
- Misalignment:
  - If pc[1:0]!=0: fetch_adef=1, only lane 0 is valid, cnt=1.
  - Sequential advance is suppressed; pc holds until a flush or branch.
- Accept condition: acc = fetch_valid & fetch_ready & ~stall.
- Next-PC priority, evaluated each edge when started=1:
  1. flush=1: pc<=flush_pc; pend_valid<=0. Applies regardless of stall or fetch_ready.
  2. stall=1 and any branch_valid: pend_valid<=1, pend_target<=target of the lowest-index asserted lane. pc holds. A later branch during the same stall overwrites the pending one.
  3. stall=1 with no branch: hold everything, including pending state.
  4. stall=0 and any branch_valid: pc<=lowest-index target; pend_valid<=0. A live branch beats a pending one. The current group is discarded whether or not it was accepted.
  5. stall=0 and pend_valid: pc<=pend_target; pend_valid<=0.
  6. acc and fetch_adef=0: pc<=pc+4*cnt.
  7. Otherwise hold (backpressure). Outputs remain stable while fetch_valid=1 and fetch_ready=0.
- Arithmetic is modulo 2^ADDR_WIDTH; PC wrap-around is permitted silently.
- Latency: a redirect is visible on fetch_pc the cycle after it is sampled.
- Reset mid-operation clears pending state and discards any in-flight group immediately.
- All outputs are combinational from registered state only. There is no input-to-output path.

Test Plan:
- Reset release, FETCH_WIDTH=2, fetch_ready=1:
  - Cycle 1: fetch_valid=0.
  - Cycle 2: fetch_pc=0x1c000000, lanes=2'b11.
  - Cycle 3: fetch_pc=0x1c000008.
- Line split, FETCH_WIDTH=4, LINE_BYTES=16:
  - Flush to 0x1c000008 → lane_valid=4'b0011, next fetch_pc=0x1c000010, then lane_valid=4'b1111.
- Backpressure:
  - fetch_ready=0 for 3 cycles at 0x1c000020 → fetch_pc and lanes held.
  - Ready high → next 0x1c000028 (W=2).
- Stall with branch:
  - stall=1, branch_valid=2'b10, target1=0x1c000100 → pc held, pend_valid=1.
  - stall=0 → fetch_pc=0x1c000100 next cycle.
  - Repeat with flush asserted in the release cycle, flush_pc=0x1c000800 → fetch_pc=0x1c000800, pending dropped.
- Simultaneous redirects:
  - branch_valid=2'b11 with targets 0x1c000200 and 0x1c000300 → 0x1c000200.
  - Same with flush=1, flush_pc=0x1c000400 → 0x1c000400.
- Misaligned target:
  - Branch to 0x1c000102 → fetch_adef=1, lane_valid=2'b01, pc held under fetch_ready=1.
  - Flush to 0x1c000000 → fetch_adef=0, fetch resumes.
